// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared states, opcodes, ALU codes and control bundle for cpu_ctrl_fsm
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6,
    PAUSE  = 3'd7
  } state_t;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_LDST = 2'b10;
  localparam logic [1:0] OP_BRZ  = 2'b11;

  localparam logic [7:0] HALT_INSTR = 8'hC0;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;
  localparam logic [2:0] ALU_OP_AND = 3'b010;
  localparam logic [2:0] ALU_OP_OR  = 3'b011;
  localparam logic [2:0] ALU_OP_XOR = 3'b100;
  localparam logic [2:0] ALU_OP_SLT = 3'b101;
  localparam logic [2:0] ALU_OP_SHL = 3'b110;
  localparam logic [2:0] ALU_OP_SHR = 3'b111;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic [5:0] instr_code;
    logic       sign_ex;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       rf_we;
    logic       wb_sel_mem;
    logic       pc_en;
    logic       pc_sel;
    logic       halted;
    logic       err;
  } ctl_t;

  function automatic logic [1:0] opcode(input logic [7:0] instr);
    return instr[7:6];
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - combinational map from state and IR to datapath controls
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter logic [2:0] ALU_ADD = ALU_OP_ADD
) (
  input  state_t     state,
  input  logic [7:0] ir,
  input  logic       imem_ready,
  input  logic       zero_flag,
  output ctl_t       ctl
);

  logic [1:0] opc;
  logic [2:0] alu_op_d;
  logic       alu_src_d;
  logic       sign_ex_d;
  logic       is_load;

  always_comb begin
    opc       = opcode(ir);
    alu_op_d  = 3'b000;
    alu_src_d = 1'b0;
    sign_ex_d = 1'b0;
    case (opc)
      OP_ALU:           alu_op_d = ir[5:3];
      OP_ADDI, OP_LDST: begin
        alu_op_d  = ALU_ADD;
        alu_src_d = 1'b1;
      end
      default:          sign_ex_d = 1'b1;
    endcase
    is_load = (opc == OP_LDST) && !ir[5];
  end

  // ALU controls stay up through WB so the combinational result is still valid at write-back
  always_comb begin
    ctl = '0;
    case (state)
      FETCH: begin
        ctl.imem_req = 1'b1;
        ctl.pc_en    = imem_ready;
      end
      DECODE: begin
        ctl.instr_code = ir[5:0];
        ctl.sign_ex    = sign_ex_d;
      end
      EXEC, MEM, WB: begin
        ctl.instr_code  = ir[5:0];
        ctl.sign_ex     = sign_ex_d;
        ctl.alu_op      = alu_op_d;
        ctl.alu_src_imm = alu_src_d;
        if (state == EXEC && opc == OP_BRZ) begin
          ctl.pc_en  = zero_flag;
          ctl.pc_sel = 1'b1;
        end
        if (state == MEM) begin
          ctl.dmem_req = 1'b1;
          ctl.dmem_we  = ir[5];
        end
        if (state == WB) begin
          ctl.rf_we      = 1'b1;
          ctl.wb_sel_mem = is_load;
        end
      end
      HALT:    ctl.halted = 1'b1;
      FAULT:   ctl.err    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle control FSM with IR and handshake timeout
// Optional single-step PAUSE state enabled by macro CPU_CTRL_STEP_EN.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [2:0]  ALU_ADD        = ALU_OP_ADD
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CPU_CTRL_STEP_EN
  input  logic       step,
`endif
  output logic       imem_req,
  input  logic       imem_ready,
  input  logic [7:0] imem_rdata,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  input  logic       zero_flag,
  output logic [5:0] instr_code,
  output logic       sign_ex,
  output logic [2:0] alu_op,
  output logic       alu_src_imm,
  output logic       rf_we,
  output logic       wb_sel_mem,
  output logic       pc_en,
  output logic       pc_sel,
  output logic       halted,
  output logic       err
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

`ifdef CPU_CTRL_STEP_EN
  localparam state_t RETURN_ST = PAUSE;
`else
  localparam state_t RETURN_ST = FETCH;
`endif

  state_t     state_q, state_d;
  logic [7:0] ir_q;
  logic [7:0] cnt_q;
  logic       ready_low;
  logic       timed_out;
  ctl_t       ctl_g;
  ctl_t       ctl_o;

  assign ready_low = (state_q == FETCH && !imem_ready) || (state_q == MEM && !dmem_ready);
  // Ready in the cycle the count hits the limit is still a success
  assign timed_out = ready_low && (cnt_q == TIMEOUT_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= 8'h00;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && imem_ready) ir_q <= imem_rdata;
      cnt_q <= (ready_low && !timed_out) ? cnt_q + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (imem_ready)     state_d = DECODE;
        else if (timed_out) state_d = FAULT;
      end
      DECODE: state_d = (ir_q == HALT_INSTR) ? HALT : EXEC;
      EXEC: begin
        case (opcode(ir_q))
          OP_ALU, OP_ADDI: state_d = WB;
          OP_LDST:         state_d = MEM;
          default:         state_d = RETURN_ST;
        endcase
      end
      MEM: begin
        if (dmem_ready)     state_d = ir_q[5] ? RETURN_ST : WB;
        else if (timed_out) state_d = FAULT;
      end
      WB: state_d = RETURN_ST;
`ifdef CPU_CTRL_STEP_EN
      PAUSE: if (step) state_d = FETCH;
`else
      PAUSE: state_d = FETCH;
`endif
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = FETCH;
    endcase
  end

  cpu_ctrl_decode #(
    .ALU_ADD(ALU_ADD)
  ) u_decode (
    .state     (state_q),
    .ir        (ir_q),
    .imem_ready(imem_ready),
    .zero_flag (zero_flag),
    .ctl       (ctl_g)
  );

  assign ctl_o       = rst ? '0 : ctl_g;
  assign imem_req    = ctl_o.imem_req;
  assign dmem_req    = ctl_o.dmem_req;
  assign dmem_we     = ctl_o.dmem_we;
  assign instr_code  = ctl_o.instr_code;
  assign sign_ex     = ctl_o.sign_ex;
  assign alu_op      = ctl_o.alu_op;
  assign alu_src_imm = ctl_o.alu_src_imm;
  assign rf_we       = ctl_o.rf_we;
  assign wb_sel_mem  = ctl_o.wb_sel_mem;
  assign pc_en       = ctl_o.pc_en;
  assign pc_sel      = ctl_o.pc_sel;
  assign halted      = ctl_o.halted;
  assign err         = ctl_o.err;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - directed bench with per-instruction output schedule model for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;

  localparam int TMO = 15;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic [5:0] instr_code;
    logic       sign_ex;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       rf_we;
    logic       wb_sel_mem;
    logic       pc_en;
    logic       pc_sel;
    logic       halted;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_ready = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       dmem_ready = 1'b0;
  logic       zero_flag = 1'b0;
`ifdef CPU_CTRL_STEP_EN
  logic       step = 1'b0;
`endif
  logic       imem_req, dmem_req, dmem_we, sign_ex, alu_src_imm, rf_we;
  logic       wb_sel_mem, pc_en, pc_sel, halted, err;
  logic [5:0] instr_code;
  logic [2:0] alu_op;

  int    checks = 0;
  int    errors = 0;
  vec_t  expq[$];
  string tagq[$];
  vec_t  act, e_c;
  string t_c;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.TIMEOUT_CYCLES(TMO), .ALU_ADD(3'b000)) dut (
    .clk(clk), .rst(rst),
`ifdef CPU_CTRL_STEP_EN
    .step(step),
`endif
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .zero_flag(zero_flag), .instr_code(instr_code), .sign_ex(sign_ex),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .rf_we(rf_we),
    .wb_sel_mem(wb_sel_mem), .pc_en(pc_en), .pc_sel(pc_sel),
    .halted(halted), .err(err)
  );

  assign act = {imem_req, dmem_req, dmem_we, instr_code, sign_ex, alu_op,
                alu_src_imm, rf_we, wb_sel_mem, pc_en, pc_sel, halted, err};

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e_c = expq.pop_front();
      t_c = tagq.pop_front();
      checks++;
      if (act !== e_c) begin
        errors++;
        $display("FAIL %s: got %05h want %05h", t_c, act, e_c);
      end
    end
  end

  function automatic void check_lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endfunction

  task automatic cyc(input logic r, input logic ir_rdy, input logic [7:0] rd,
                     input logic dr, input logic zf, input vec_t e, input string t);
    @(posedge clk);
    #1;
    rst        = r;
    imem_ready = ir_rdy;
    imem_rdata = rd;
    dmem_ready = dr;
    zero_flag  = zf;
`ifdef CPU_CTRL_STEP_EN
    step = 1'b0;
`endif
    expq.push_back(e);
    tagq.push_back(t);
  endtask

  function automatic vec_t fetch_vec(input logic rdy);
    vec_t v = '0;
    v.imem_req = 1'b1;
    v.pc_en    = rdy;
    return v;
  endfunction

  // ISA-level view: what the datapath must see while an instruction is being executed
  function automatic vec_t exec_vec(input logic [7:0] ins);
    vec_t v = '0;
    v.instr_code = ins[5:0];
    v.sign_ex    = (ins[7:6] == 2'b11);
    if (ins[7:6] == 2'b00) begin
      v.alu_op = ins[5:3];
    end else if (ins[7:6] != 2'b11) begin
      v.alu_op      = 3'b000;
      v.alu_src_imm = 1'b1;
    end
    return v;
  endfunction

  task automatic ret_to_fetch();
`ifdef CPU_CTRL_STEP_EN
    cyc(0, 1, 8'h4B, 0, 0, '0, "pause");
    cyc(0, 0, 8'h00, 0, 0, '0, "pause");
    step = 1'b1;
`endif
  endtask

  task automatic run_instr(input logic [7:0] ins, input int fwait, input int mwait, input logic zf);
    vec_t v;
    vec_t b;
    for (int i = 0; i < fwait && i <= TMO; i++) cyc(0, 0, 8'h00, 0, 0, fetch_vec(0), "fetch_wait");
    if (fwait > TMO) return;
    cyc(0, 1, ins, 0, 0, fetch_vec(1), "fetch");
    v = '0;
    v.instr_code = ins[5:0];
    v.sign_ex    = (ins[7:6] == 2'b11);
    cyc(0, 0, 8'h00, 0, 0, v, "decode");
    if (ins == 8'hC0) return;
    b = exec_vec(ins);
    v = b;
    if (ins[7:6] == 2'b11) begin
      v.pc_en  = zf;
      v.pc_sel = 1'b1;
    end
    cyc(0, 0, 8'h00, 0, zf, v, "exec");
    if (ins[7:6] == 2'b10) begin
      for (int i = 0; i <= mwait && i <= TMO; i++) begin
        v = b;
        v.dmem_req = 1'b1;
        v.dmem_we  = ins[5];
        cyc(0, 0, 8'h00, (i == mwait), 0, v, "mem");
      end
      if (mwait > TMO) return;
    end
    if (ins[7:6] != 2'b11 && !(ins[7:6] == 2'b10 && ins[5])) begin
      v = b;
      v.rf_we      = 1'b1;
      v.wb_sel_mem = (ins[7:6] == 2'b10);
      cyc(0, 0, 8'h00, 0, 0, v, "wb");
    end
  endtask

  initial begin
    vec_t v;
    cyc(1, 0, 8'h00, 0, 0, '0, "reset");
    cyc(1, 1, 8'h4B, 1, 1, '0, "reset");
    @(negedge clk);
    check_lit("reset_imem_req", int'(imem_req), 0);

    run_instr(8'h4B, 0, 0, 0);
    @(negedge clk);
    check_lit("addi_wb_rf_we", int'(rf_we), 1);
    check_lit("addi_wb_src_imm", int'(alu_src_imm), 1);
    ret_to_fetch();

    run_instr(8'h85, 1, 3, 0);
    @(negedge clk);
    check_lit("ld_wb_sel_mem", int'(wb_sel_mem), 1);
    ret_to_fetch();

    run_instr(8'hA5, 0, 0, 0);
    ret_to_fetch();
    run_instr(8'h2A, 2, 0, 0);
    ret_to_fetch();

    run_instr(8'hFE, 0, 0, 1);
    @(negedge clk);
    check_lit("brz_taken_pc", int'({pc_en, pc_sel}), 3);
    check_lit("brz_instr_code", int'(instr_code), 8'h3E);
    ret_to_fetch();
    run_instr(8'hFE, 0, 0, 0);
    @(negedge clk);
    check_lit("brz_not_taken_pc_en", int'(pc_en), 0);
    ret_to_fetch();

    run_instr(8'h4B, TMO, 0, 0);
    ret_to_fetch();
    run_instr(8'h85, 0, TMO, 0);
    ret_to_fetch();

    run_instr(8'h4B, TMO + 1, 0, 0);
    v = '0;
    v.err = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, i[0], 8'h4B, 1, 0, v, "fetch_fault");
    @(negedge clk);
    check_lit("fault_err", int'(err), 1);
    check_lit("fault_imem_req", int'(imem_req), 0);
    cyc(1, 0, 8'h00, 0, 0, '0, "reset");

    run_instr(8'hA5, 0, TMO + 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1, 0, v, "mem_fault");
    cyc(1, 0, 8'h00, 0, 0, '0, "reset");

    run_instr(8'hC0, 0, 0, 0);
    v = '0;
    v.halted = 1'b1;
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'h4B, 1, 1, v, "halt");
    @(negedge clk);
    check_lit("halt_sticky", int'(halted), 1);
    cyc(1, 0, 8'h00, 0, 0, '0, "reset");

    run_instr(8'h85, 0, TMO + 1, 0);
    cyc(1, 0, 8'h00, 0, 0, '0, "reset_mid_mem");
    cyc(0, 0, 8'h00, 0, 0, fetch_vec(0), "post_reset");
    @(negedge clk);
    check_lit("post_reset_imem_req", int'(imem_req), 1);
    check_lit("post_reset_dmem_req", int'(dmem_req), 0);
    run_instr(8'h4B, 0, 0, 0);
    ret_to_fetch();

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
